// File: rtl/parking_meter_gen_if.sv
// Handshake-free signal bundle for parking_meter_gen: coin/preset inputs and
// display/status outputs. The master side drives inputs; the slave is the meter.
interface parking_meter_gen_if #(
  parameter int unsigned DIGITS = 4
);
  logic [3:0]          coin;
  logic                preset_a;
  logic                preset_b;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic [4*DIGITS-1:0] bcd;
  logic [1:0]          mode;
  logic                busy;

  modport master (
    output coin, preset_a, preset_b,
    input  seg, an, bcd, mode, busy
  );

  modport slave (
    input  coin, preset_a, preset_b,
    output seg, an, bcd, mode, busy
  );
endinterface

// File: rtl/parking_meter_gen.sv
// Countdown parking meter core: coin/preset loading, 1 s decrement, iterative
// binary-to-BCD conversion and multiplexed seven-segment drive.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module parking_meter_gen #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned TW            = 14,
  parameter int unsigned LOW_THRESH    = 180,
  parameter int unsigned COIN0         = 60,
  parameter int unsigned COIN1         = 120,
  parameter int unsigned COIN2         = 180,
  parameter int unsigned COIN3         = 300,
  parameter int unsigned PRESET_A      = 16,
  parameter int unsigned PRESET_B      = 150,
  parameter int unsigned SCAN_DIV      = 4
) (
  input  logic               clk,
  input  logic               rst,
  parking_meter_gen_if.slave bus
);

  localparam int unsigned MAX_VAL = 10**DIGITS - 1;
  localparam int unsigned BW      = 4 * DIGITS;
  localparam int unsigned CW      = $clog2(TICKS_PER_SEC);
  localparam int unsigned SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NW      = $clog2(TW + 1);

  localparam logic [TW:0]   MAX_EXT   = (TW+1)'(MAX_VAL);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] TICK_HALF = CW'(TICKS_PER_SEC / 2);

  typedef enum logic [1:0] {
    MODE_EXPIRED = 2'd0,
    MODE_LOW     = 2'd1,
    MODE_OK      = 2'd2
  } mode_t;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } bcd_state_t;

  function automatic logic [BW+TW-1:0] dd_step(input logic [BW+TW-1:0] v);
    logic [BW+TW-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r[TW+4*i +: 4] >= 4'd5) r[TW+4*i +: 4] = r[TW+4*i +: 4] + 4'd3;
    end
    return {r[BW+TW-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------- time keeping ----------------
  logic [TW-1:0] secs, secs_next;
  logic [CW-1:0] tick_cnt, tick_next;
  logic [3:0]    coin_q, coin_edge;
  logic [TW:0]   coin_add, coin_sum;
  logic          tick_wrap;
  mode_t         mode_q, mode_next;

  always_comb begin
    coin_edge = bus.coin & ~coin_q;
    tick_wrap = (tick_cnt == TICK_LAST);
  end

  // Lowest-index edge wins; higher simultaneous edges are dropped.
  always_comb begin
    coin_add = '0;
    if (coin_edge[0])      coin_add = (TW+1)'(COIN0);
    else if (coin_edge[1]) coin_add = (TW+1)'(COIN1);
    else if (coin_edge[2]) coin_add = (TW+1)'(COIN2);
    else if (coin_edge[3]) coin_add = (TW+1)'(COIN3);
    coin_sum = {1'b0, secs} + coin_add;
  end

  always_comb begin
    secs_next = secs;
    tick_next = tick_wrap ? '0 : tick_cnt + CW'(1);
    if (bus.preset_a) begin
      secs_next = TW'(PRESET_A);
      tick_next = '0;
    end else if (bus.preset_b) begin
      secs_next = TW'(PRESET_B);
      tick_next = '0;
    end else if (|coin_edge) begin
      secs_next = (coin_sum > MAX_EXT) ? MAX_EXT[TW-1:0] : coin_sum[TW-1:0];
      tick_next = '0;
    end else if (tick_wrap && (secs != '0)) begin
      secs_next = secs - TW'(1);
    end

    if (secs_next == '0)                   mode_next = MODE_EXPIRED;
    else if (secs_next <= TW'(LOW_THRESH)) mode_next = MODE_LOW;
    else                                   mode_next = MODE_OK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      secs     <= '0;
      tick_cnt <= '0;
      coin_q   <= '0;
      mode_q   <= MODE_EXPIRED;
    end else begin
      secs     <= secs_next;
      tick_cnt <= tick_next;
      coin_q   <= bus.coin;
      mode_q   <= mode_next;
    end
  end

  // ---------------- BCD conversion ----------------
  bcd_state_t       state, state_next;
  logic [TW-1:0]    last_conv;
  logic [BW+TW-1:0] work, work_step;
  logic [NW-1:0]    shift_cnt;
  logic [BW-1:0]    bcd_q;
  logic             busy_q;
  logic             start, finish;

  always_comb work_step = dd_step(work);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (secs != last_conv) begin
          start      = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_cnt == NW'(TW - 1)) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
    endcase
  end

  // The final shift writes bcd directly, giving TW+1 cycles from change to result.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_conv <= '0;
      work      <= '0;
      shift_cnt <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
    end else if (start) begin
      work      <= {{BW{1'b0}}, secs};
      last_conv <= secs;
      shift_cnt <= '0;
      busy_q    <= 1'b1;
    end else if (state == S_SHIFT) begin
      work      <= work_step;
      shift_cnt <= shift_cnt + NW'(1);
      if (finish) begin
        bcd_q  <= work_step[BW+TW-1:TW];
        busy_q <= 1'b0;
      end
    end
  end

  // ---------------- display scan ----------------
  logic [SW-1:0]     scan_cnt;
  logic [IW-1:0]     scan_idx;
  logic [3:0]        digit;
  logic              blank;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;

  always_comb begin
    digit = bcd_q[4*scan_idx +: 4];
    case (mode_q)
      MODE_EXPIRED: blank = (tick_cnt >= TICK_HALF);
      MODE_LOW:     blank = secs[0];
      default:      blank = 1'b0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((scan_idx != '0) && ((bcd_q >> (4*scan_idx)) == '0)) blank = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an_q     <= '1;
      seg_q    <= '1;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      an_q  <= blank ? '1 : ~(DIGITS'(1) << scan_idx);
      seg_q <= seg_decode(digit);
    end
  end

  always_comb begin
    bus.seg  = seg_q;
    bus.an   = an_q;
    bus.bcd  = bcd_q;
    bus.mode = mode_q;
    bus.busy = busy_q;
  end

endmodule

// File: tb/tb_parking_meter_gen.sv
// Randomized + directed bench for parking_meter_gen against an arithmetic
// reference model of remaining seconds, tick phase and scan position.
module tb_parking_meter_gen;

  localparam int TPS = 100;
  localparam int D   = 4;
  localparam int TWP = 14;
  localparam int SD  = 4;
  localparam int SETTLE = 2*TWP + 2;

  logic clk = 1'b0;
  logic rst;

  parking_meter_gen_if #(.DIGITS(D)) bus();

  parking_meter_gen #(
    .TICKS_PER_SEC(TPS),
    .DIGITS(D),
    .TW(TWP),
    .SCAN_DIV(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_secs   = 0;
  int m_tick   = 0;
  int m_n      = 0;
  int m_stable = 1000;
  logic [3:0] m_cq = '0;

  int coin_val [4] = '{60, 120, 180, 300};
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] dec(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int mode_of(input int v);
    if (v == 0)   return 0;
    if (v <= 180) return 1;
    return 2;
  endfunction

  task automatic model_update();
    logic [3:0] edges;
    int nxt;
    bit restart;
    edges  = bus.coin & ~m_cq;
    m_cq   = bus.coin;
    nxt    = m_secs;
    restart = 1'b1;
    if (bus.preset_a)      nxt = 16;
    else if (bus.preset_b) nxt = 150;
    else if (edges != 0) begin
      for (int k = 3; k >= 0; k--) if (edges[k]) nxt = m_secs + coin_val[k];
      if (nxt > 9999) nxt = 9999;
    end else restart = 1'b0;
    if (restart) m_tick = 0;
    else if (m_tick == TPS - 1) begin
      m_tick = 0;
      if (m_secs > 0) nxt = m_secs - 1;
    end else m_tick++;
    if (nxt != m_secs) m_stable = 0;
    else if (m_stable < 1000) m_stable++;
    m_secs = nxt;
    m_n++;
  endtask

  task automatic step();
    int idx;
    bit blank, chk_seg, chk_an, pre_settled;
    logic [D-1:0] exp_an;
    logic [6:0] exp_seg;
    @(posedge clk);
    idx = (m_n / SD) % D;
    pre_settled = (m_stable >= SETTLE);
    case (mode_of(m_secs))
      0:       blank = (m_tick >= TPS/2);
      1:       blank = (m_secs % 2 == 1);
      default: blank = 1'b0;
    endcase
    chk_an = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && m_secs < 10**idx) blank = 1'b1;
    chk_an = pre_settled;
`endif
    exp_seg = seg_tab[(m_secs / (10**idx)) % 10];
    if (rst) begin
      exp_an  = '1;
      exp_seg = 7'b1111111;
      chk_seg = 1'b1;
      chk_an  = 1'b1;
      m_secs = 0; m_tick = 0; m_n = 0; m_stable = 1000; m_cq = '0;
    end else begin
      exp_an  = blank ? '1 : ~(D'(1) << idx);
      chk_seg = !blank && pre_settled;
      model_update();
    end
    @(negedge clk);
    chk("mode", bus.mode, mode_of(m_secs));
    if (chk_an)  chk("an", bus.an, exp_an);
    if (chk_seg) chk("seg", bus.seg, exp_seg);
    if (m_stable >= SETTLE) begin
      chk("bcd", bus.bcd, dec(m_secs));
      chk("busy", bus.busy, 0);
    end
  endtask

  task automatic pulse(input logic [3:0] c);
    bus.coin = c;
    step();
    bus.coin = '0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.coin = '0;
    bus.preset_a = 1'b0;
    bus.preset_b = 1'b0;
    repeat (3) step();
    chk("rst_an", bus.an, 4'hf);
    chk("rst_seg", bus.seg, 7'h7f);
    chk("rst_bcd", bus.bcd, 0);
    rst = 1'b0;

    // idle while expired: 1 Hz blink checked every cycle
    repeat (3*TPS) step();

    // coin[3] from zero: exact conversion latency, then countdown into LOW
    bus.coin = 4'b1000;
    step();
    bus.coin = '0;
    step();
    chk("busy_start", bus.busy, 1);
    repeat (TWP-1) step();
    chk("bcd_before", bus.bcd, 16'h0000);
    step();
    chk("bcd_300", bus.bcd, 16'h0300);
    chk("mode_ok", bus.mode, 2);
    repeat (120*TPS - (TWP+1)) step();
    repeat (TWP+1) step();
    chk("bcd_180", bus.bcd, 16'h0180);
    chk("mode_low", bus.mode, 1);

    // simultaneous coin[0]+coin[2] held high: only one 60 s add
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.coin = 4'b0101;
    repeat (50) step();
    chk("bcd_60", bus.bcd, 16'h0060);
    bus.coin = '0;
    step();

    // saturation at 9999 and the following decrement
    for (int p = 0; p < 34; p++) pulse(4'b1000);
    repeat (SETTLE) step();
    chk("bcd_sat", bus.bcd, 16'h9999);
    repeat (TPS - (SETTLE + 1)) step();
    repeat (TWP+1) step();
    chk("bcd_9998", bus.bcd, 16'h9998);

    // preset_a beats a same-cycle coin edge; count down to expiry
    bus.preset_a = 1'b1;
    bus.coin = 4'b0010;
    step();
    bus.preset_a = 1'b0;
    bus.coin = '0;
    step();
    repeat (SETTLE) step();
    chk("bcd_16", bus.bcd, 16'h0016);
    repeat (16*TPS - 1 - SETTLE) step();
    chk("mode_exp", bus.mode, 0);
    repeat (TWP+1) step();
    chk("bcd_zero", bus.bcd, 16'h0000);

    // reset during an active conversion
    pulse(4'b1000);
    step();
    chk("busy_mid", bus.busy, 1);
    rst = 1'b1;
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_bcd2", bus.bcd, 0);
    chk("rst_an2", bus.an, 4'hf);
    rst = 1'b0;

    // randomized coins and presets
    repeat (4000) begin
      if ($urandom_range(0, 29) == 0) bus.coin = 4'($urandom_range(0, 15));
      bus.preset_a = ($urandom_range(0, 299) == 0);
      bus.preset_b = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.coin = '0;
    bus.preset_a = 1'b0;
    bus.preset_b = 1'b0;
    repeat (SETTLE + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
